// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite command master: FSM state encoding,
// AXI response codes and the fixed sideband values driven on the master port.
package axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] WSTRB_ALL    = 4'hF;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  // SLVERR and DECERR are errors; OKAY and EXOKAY are not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master driven by a simple core-side command
// port. Each accepted command becomes one single-beat read or write; the
// result comes back as a one-cycle response strobe with registered data/error.
//
// Handshake semantics: on the AXI side a transfer happens on a rising edge
// where valid and ready are both high; a valid, once raised, stays high with
// stable address/data until that edge. On the core side the requester holds
// i_valid until o_rsp_stb; a command is accepted only in IDLE, and
// o_cmd_busy covers the cycle after accept through the strobe cycle.
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  // core-side command port
  input  logic              i_valid,
  input  logic              i_write,
  input  logic [3:0]        i_addr,
  input  logic [31:0]       i_data,
  output logic              o_cmd_busy,
  output logic              o_rsp_stb,
  output logic [31:0]       o_rsp_word,
  output logic              o_rsp_err,
  // AXI4-Lite write address channel
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [2:0]        m_awprot,
  // AXI4-Lite write data channel
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  // AXI4-Lite write response channel
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  // AXI4-Lite read address channel
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [2:0]        m_arprot,
  // AXI4-Lite read data channel
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready,
  // debug view of the FSM state
  output logic [2:0]        dbg_state
);

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic                aw_done;
  logic                w_done;
  logic [ADDR_W-1:0]   cmd_addr;
  logic                aw_hs;
  logic                w_hs;

  // Word index to byte address, wrapping modulo 2^ADDR_W.
  assign cmd_addr = ADDR_W'(BASE_ADDR) + ADDR_W'({i_addr, 2'b00});

  assign aw_hs = m_awvalid && m_awready;
  assign w_hs  = m_wvalid && m_wready;

  // One register holds the address for whichever channel is in use.
  assign m_awaddr  = addr_q;
  assign m_araddr  = addr_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = WSTRB_ALL;
  assign m_awprot  = PROT_DEFAULT;
  assign m_arprot  = PROT_DEFAULT;
  assign dbg_state = state;

  // Command FSM with all handshake and response outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      m_awvalid  <= 1'b0;
      m_wvalid   <= 1'b0;
      m_bready   <= 1'b0;
      m_arvalid  <= 1'b0;
      m_rready   <= 1'b0;
      o_cmd_busy <= 1'b0;
      o_rsp_stb  <= 1'b0;
      o_rsp_word <= '0;
      o_rsp_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid && !o_rsp_stb) begin
            addr_q     <= cmd_addr;
            wdata_q    <= i_data;
            o_cmd_busy <= 1'b1;
            if (i_write) begin
              state     <= ST_WADDR;
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
            end else begin
              state     <= ST_RADDR;
              m_arvalid <= 1'b1;
            end
          end
        end

        // AW and W complete independently; leave once both are done,
        // counting a handshake happening this very cycle.
        ST_WADDR: begin
          if (aw_hs) begin
            m_awvalid <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            m_wvalid <= 1'b0;
            w_done   <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state    <= ST_WRESP;
            m_bready <= 1'b1;
          end
        end

        ST_WRESP: begin
          if (m_bvalid) begin
            state      <= ST_RESP;
            m_bready   <= 1'b0;
            o_rsp_word <= '0;
            o_rsp_err  <= resp_is_err(m_bresp);
            o_rsp_stb  <= 1'b1;
          end
        end

        ST_RADDR: begin
          if (m_arready) begin
            state     <= ST_RDATA;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
          end
        end

        ST_RDATA: begin
          if (m_rvalid) begin
            state      <= ST_RESP;
            m_rready   <= 1'b0;
            o_rsp_word <= m_rdata;
            o_rsp_err  <= resp_is_err(m_rresp);
            o_rsp_stb  <= 1'b1;
          end
        end

        // Strobe cycle; word/err keep their value until the next response.
        ST_RESP: begin
          state      <= ST_IDLE;
          o_rsp_stb  <= 1'b0;
          o_cmd_busy <= 1'b0;
        end

        default: begin
          state      <= ST_IDLE;
          m_awvalid  <= 1'b0;
          m_wvalid   <= 1'b0;
          m_bready   <= 1'b0;
          m_arvalid  <= 1'b0;
          m_rready   <= 1'b0;
          o_rsp_stb  <= 1'b0;
          o_cmd_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: a configurable-latency AXI4-Lite slave, a
// protocol monitor, a directed vector table and randomized commands checked
// against a latency/response model derived from the command description.
module tb_axil_cmd_master;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_write = 1'b0;
  logic [3:0]  i_addr = '0;
  logic [31:0] i_data = '0;
  logic        o_cmd_busy, o_rsp_stb, o_rsp_err;
  logic [31:0] o_rsp_word;
  logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [3:0]  m_wstrb;
  logic [2:0]  m_awprot, m_arprot, dbg_state;
  logic [1:0]  m_bresp, m_rresp;

  axil_cmd_master #(.BASE_ADDR(BASE), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_write(i_write), .i_addr(i_addr), .i_data(i_data),
    .o_cmd_busy(o_cmd_busy), .o_rsp_stb(o_rsp_stb), .o_rsp_word(o_rsp_word),
    .o_rsp_err(o_rsp_err),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_awprot(m_awprot),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_arprot(m_arprot),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  // Each delay is the number of cycles the master's valid/ready is held
  // before the slave answers, so that signal is high for delay+1 cycles.
  int          cfg_da = 0;   // AW (writes) or AR (reads)
  int          cfg_dw = 0;   // W
  int          cfg_db = 0;   // B (writes) or R (reads)
  logic [1:0]  cfg_resp = 2'b00;
  logic [31:0] cfg_rdata = '0;
  int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;

  assign m_awready = m_awvalid && (aw_wait >= cfg_da);
  assign m_wready  = m_wvalid  && (w_wait  >= cfg_dw);
  assign m_bvalid  = m_bready  && (b_wait  >= cfg_db);
  assign m_arready = m_arvalid && (ar_wait >= cfg_da);
  assign m_rvalid  = m_rready  && (r_wait  >= cfg_db);
  assign m_bresp   = cfg_resp;
  assign m_rresp   = cfg_resp;
  assign m_rdata   = cfg_rdata;

  always @(posedge clk) begin
    aw_wait <= (m_awvalid && !m_awready) ? aw_wait + 1 : 0;
    w_wait  <= (m_wvalid  && !m_wready)  ? w_wait  + 1 : 0;
    b_wait  <= (m_bready  && !m_bvalid)  ? b_wait  + 1 : 0;
    ar_wait <= (m_arvalid && !m_arready) ? ar_wait + 1 : 0;
    r_wait  <= (m_rready  && !m_rvalid)  ? r_wait  + 1 : 0;
  end

  // ---------------- protocol monitor ----------------
  int aw_hi = 0, w_hi = 0, b_hi = 0, ar_hi = 0, r_hi = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  int viol = 0;
  logic [31:0] hs_awaddr = '0, hs_wdata = '0, hs_araddr = '0;
  logic aw_pend = 0, w_pend = 0, ar_pend = 0;
  logic [31:0] aw_pend_v = '0, w_pend_v = '0, ar_pend_v = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      ar_pend <= 1'b0;
    end else begin
      int v;
      v = 0;
      if (aw_pend && (!m_awvalid || m_awaddr != aw_pend_v)) v++;
      if (w_pend  && (!m_wvalid  || m_wdata  != w_pend_v))  v++;
      if (ar_pend && (!m_arvalid || m_araddr != ar_pend_v)) v++;
      if (m_wstrb != 4'hF || m_awprot != 3'b000 || m_arprot != 3'b000) v++;
      if ((m_awvalid || m_wvalid || m_bready) && (m_arvalid || m_rready)) v++;
      viol <= viol + v;
      aw_pend   <= m_awvalid && !m_awready;
      w_pend    <= m_wvalid && !m_wready;
      ar_pend   <= m_arvalid && !m_arready;
      aw_pend_v <= m_awaddr;
      w_pend_v  <= m_wdata;
      ar_pend_v <= m_araddr;
      if (m_awvalid) aw_hi <= aw_hi + 1;
      if (m_wvalid)  w_hi  <= w_hi + 1;
      if (m_bready)  b_hi  <= b_hi + 1;
      if (m_arvalid) ar_hi <= ar_hi + 1;
      if (m_rready)  r_hi  <= r_hi + 1;
      if (m_awvalid && m_awready) begin aw_hs <= aw_hs + 1; hs_awaddr <= m_awaddr; end
      if (m_wvalid && m_wready)   begin w_hs  <= w_hs + 1;  hs_wdata  <= m_wdata;  end
      if (m_bready && m_bvalid)   b_hs <= b_hs + 1;
      if (m_arvalid && m_arready) begin ar_hs <= ar_hs + 1; hs_araddr <= m_araddr; end
      if (m_rready && m_rvalid)   r_hs <= r_hs + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        write;
    logic [3:0]  addr;
    logic [31:0] data;
    int          da;
    int          dw;
    int          db;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_word;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  // Reference model: byte address from word index, response from the slave's
  // answer, and latency as 3 cycles plus every cycle the slave makes us wait
  // (AW and W wait in parallel).
  function automatic vec_t model(input vec_t v);
    vec_t r;
    r = v;
    r.exp_addr = BASE + 32'(v.addr) * 4;
    r.exp_word = v.write ? 32'h0 : v.rdata;
    r.exp_err  = v.resp[1];
    r.exp_lat  = 3 + (v.write ? ((v.da > v.dw ? v.da : v.dw) + v.db) : (v.da + v.db));
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic run_cmd(input vec_t v, input string tag);
    int n;
    logic got, busy_ok;
    int aw_hi0, w_hi0, b_hi0, ar_hi0, r_hi0, aw_hs0, w_hs0, ar_hs0, viol0;
    cfg_da = v.da; cfg_dw = v.dw; cfg_db = v.db;
    cfg_resp = v.resp; cfg_rdata = v.rdata;
    aw_hi0 = aw_hi; w_hi0 = w_hi; b_hi0 = b_hi; ar_hi0 = ar_hi; r_hi0 = r_hi;
    aw_hs0 = aw_hs; w_hs0 = w_hs; ar_hs0 = ar_hs; viol0 = viol;
    @(negedge clk);
    i_valid = 1'b1; i_write = v.write; i_addr = v.addr; i_data = v.data;
    n = 0; got = 1'b0; busy_ok = 1'b1;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (o_rsp_stb) begin got = 1'b1; break; end
      if (!o_cmd_busy) busy_ok = 1'b0;
    end
    i_valid = 1'b0;
    check({tag, " strobe_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, " latency"}, 32'(n), 32'(v.exp_lat));
      check({tag, " rsp_word"}, o_rsp_word, v.exp_word);
      check({tag, " rsp_err"}, 32'(o_rsp_err), 32'(v.exp_err));
      check({tag, " busy_during"}, 32'(busy_ok && o_cmd_busy), 32'd1);
    end
    @(posedge clk); #1;
    check({tag, " strobe_one_cycle"}, 32'(o_rsp_stb), 32'd0);
    check({tag, " idle_not_busy"}, 32'(o_cmd_busy), 32'd0);
    check({tag, " word_held"}, o_rsp_word, v.exp_word);
    check({tag, " protocol"}, 32'(viol - viol0), 32'd0);
    if (v.write) begin
      check({tag, " awaddr"}, hs_awaddr, v.exp_addr);
      check({tag, " wdata"}, hs_wdata, v.data);
      check({tag, " aw_hs"}, 32'(aw_hs - aw_hs0), 32'd1);
      check({tag, " w_hs"}, 32'(w_hs - w_hs0), 32'd1);
      check({tag, " awvalid_cycles"}, 32'(aw_hi - aw_hi0), 32'(v.da + 1));
      check({tag, " wvalid_cycles"}, 32'(w_hi - w_hi0), 32'(v.dw + 1));
      check({tag, " bready_cycles"}, 32'(b_hi - b_hi0), 32'(v.db + 1));
      check({tag, " no_read"}, 32'(ar_hi - ar_hi0), 32'd0);
    end else begin
      check({tag, " araddr"}, hs_araddr, v.exp_addr);
      check({tag, " ar_hs"}, 32'(ar_hs - ar_hs0), 32'd1);
      check({tag, " arvalid_cycles"}, 32'(ar_hi - ar_hi0), 32'(v.da + 1));
      check({tag, " rready_cycles"}, 32'(r_hi - r_hi0), 32'(v.db + 1));
      check({tag, " no_write"}, 32'(aw_hi - aw_hi0 + w_hi - w_hi0), 32'd0);
    end
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[8];
  vec_t rv;

  initial begin
    //          wr  addr  data           da dw db resp   rdata          exp_addr       exp_word       err lat
    tbl[0] = '{1'b0, 4'h3, 32'h0,         0, 0, 0, 2'b00, 32'hCAFE_F00D, 32'h4000_000C, 32'hCAFE_F00D, 1'b0, 3};
    tbl[1] = '{1'b1, 4'h1, 32'h1234_5678, 2, 0, 0, 2'b00, 32'h0,         32'h4000_0004, 32'h0,         1'b0, 5};
    tbl[2] = '{1'b1, 4'h7, 32'hA5A5_5A5A, 1, 3, 0, 2'b10, 32'h0,         32'h4000_001C, 32'h0,         1'b1, 6};
    tbl[3] = '{1'b0, 4'h9, 32'h0,         0, 0, 4, 2'b11, 32'h1357_9BDF, 32'h4000_0024, 32'h1357_9BDF, 1'b1, 7};
    tbl[4] = '{1'b1, 4'h0, 32'hFFFF_FFFF, 0, 0, 0, 2'b11, 32'h0,         32'h4000_0000, 32'h0,         1'b1, 3};
    tbl[5] = '{1'b0, 4'hF, 32'h0,         3, 0, 2, 2'b10, 32'h0,         32'h4000_003C, 32'h0,         1'b1, 8};
    tbl[6] = '{1'b1, 4'hF, 32'h0,         4, 1, 3, 2'b01, 32'h0,         32'h4000_003C, 32'h0,         1'b0, 10};
    tbl[7] = '{1'b1, 4'h5, 32'h0BAD_BEEF, 2, 2, 1, 2'b00, 32'h0,         32'h4000_0014, 32'h0,         1'b0, 6};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {24'h0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                         o_rsp_stb, o_cmd_busy, o_rsp_err}, 32'h0);
    check("reset_word", o_rsp_word, 32'h0);
    check("reset_awaddr", m_awaddr, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // directed table
    for (int i = 0; i < 8; i++) run_cmd(tbl[i], $sformatf("vec%0d", i));

    // continuous i_valid across two reads
    begin
      int ar0, t, t1, t2;
      logic [31:0] w1, w2;
      cfg_da = 0; cfg_dw = 0; cfg_db = 0; cfg_resp = 2'b00; cfg_rdata = 32'h1111_2222;
      ar0 = ar_hs; t = 0; t1 = -1; t2 = -1; w1 = '0; w2 = '0;
      @(negedge clk);
      i_valid = 1'b1; i_write = 1'b0; i_addr = 4'h2;
      while (t < 60 && t2 < 0) begin
        @(posedge clk); #1;
        t++;
        if (o_rsp_stb) begin
          if (t1 < 0) begin t1 = t; w1 = o_rsp_word; cfg_rdata = 32'h3333_4444; end
          else begin t2 = t; w2 = o_rsp_word; end
        end
      end
      i_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("b2b first_latency", 32'(t1), 32'd3);
      check("b2b strobe_gap", 32'(t2 - t1), 32'd4);
      check("b2b ar_handshakes", 32'(ar_hs - ar0), 32'd2);
      check("b2b word1", w1, 32'h1111_2222);
      check("b2b word2", w2, 32'h3333_4444);
    end

    // asynchronous reset while waiting for read data
    begin
      int stb_seen;
      cfg_da = 0; cfg_db = 1000; cfg_resp = 2'b00; cfg_rdata = 32'hDEAD_0001;
      @(negedge clk);
      i_valid = 1'b1; i_write = 1'b0; i_addr = 4'h6;
      repeat (3) @(posedge clk);
      #1;
      i_valid = 1'b0;
      check("rst_mid in_rdata", 32'(m_rready && o_cmd_busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_mid ctrl", {24'h0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                             o_rsp_stb, o_cmd_busy, o_rsp_err}, 32'h0);
      check("rst_mid word", o_rsp_word, 32'h0);
      check("rst_mid araddr", m_araddr, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      stb_seen = 0;
      repeat (4) begin
        @(posedge clk); #1;
        if (o_rsp_stb || o_cmd_busy) stb_seen++;
      end
      check("rst_mid no_response", 32'(stb_seen), 32'd0);
      rv = '{1'b0, 4'h6, 32'h0, 1, 0, 1, 2'b00, 32'h7777_8888, 32'h0, 32'h0, 1'b0, 0};
      run_cmd(model(rv), "post_reset");
    end

    // randomized commands against the model
    for (int k = 0; k < 30; k++) begin
      rv.write = 1'($urandom_range(0, 1));
      rv.addr  = 4'($urandom_range(0, 15));
      rv.data  = $urandom;
      rv.da    = $urandom_range(0, 4);
      rv.dw    = $urandom_range(0, 4);
      rv.db    = $urandom_range(0, 4);
      rv.resp  = 2'($urandom_range(0, 3));
      rv.rdata = $urandom;
      run_cmd(model(rv), $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // overall time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
